// File: rtl/fetch_decode_ctrl_if.sv
// fetch_decode_ctrl_if: instruction-memory fetch handshake bundle.
//   req   - fetch request from the sequencer, held until ack
//   addr  - 5-bit fetch address (the PC)
//   ack   - memory presents valid data on rdata this cycle
//   rdata - 8-bit instruction byte
// master: the fetch sequencer; slave: the instruction memory.
interface fetch_decode_ctrl_if;
    logic       req;
    logic [4:0] addr;
    logic       ack;
    logic [7:0] rdata;
    modport master (output req, addr, input ack, rdata);
    modport slave  (input req, addr, output ack, rdata);
endinterface

// File: rtl/fetch_decode_ctrl.sv
// fetch_decode_ctrl: multicycle fetch/decode sequencer for the 8-bit CPU.
// Fetches one instruction per pass over a req/ack handshake, decodes it into
// register selects and control lines, emits stage-event toggles and owns the PC.
// Ports:
//   clk, rst_n         - clock, asynchronous active-low reset
//   i_run              - keep fetching/executing while high
//   bus (master)       - instruction memory handshake (req/addr/ack/rdata)
//   o_instruction      - latched instruction byte
//   o_rt_or_rd, o_rs   - register selects (instruction[4], instruction[3])
//   o_imm              - instruction[2:0]
//   o_reg_write, o_mem_read, o_mem_write, o_alu_src, o_mem_to_reg, o_alu_op
//                      - decoded controls
//   o_id/ex/mem/wb_stage - stage-event toggles
//   o_pc               - current PC
//   o_illegal_op       - sticky illegal-opcode flag
//   o_busy             - high in every state except IDLE and HALTED
// Build option: define FDC_HALT_ON_ILLEGAL_EN to halt on an illegal opcode
// instead of treating it as a NOP.
module fetch_decode_ctrl #(
    parameter logic [4:0] RESET_PC = 5'd0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_run,
    fetch_decode_ctrl_if.master bus,
    output logic [7:0]          o_instruction,
    output logic                o_rt_or_rd,
    output logic                o_rs,
    output logic [2:0]          o_imm,
    output logic                o_reg_write,
    output logic                o_mem_read,
    output logic                o_mem_write,
    output logic                o_alu_src,
    output logic                o_mem_to_reg,
    output logic [1:0]          o_alu_op,
    output logic                o_id_stage,
    output logic                o_ex_stage,
    output logic                o_mem_stage,
    output logic                o_wb_stage,
    output logic [4:0]          o_pc,
    output logic                o_illegal_op,
    output logic                o_busy
);
    typedef enum logic [2:0] {
`ifdef FDC_HALT_ON_ILLEGAL_EN
        S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_WRITEBACK, S_HALTED
`else
        S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_WRITEBACK
`endif
    } state_t;

    state_t     r_state;
    logic [4:0] r_pc;
    logic [7:0] r_instr;
    logic       r_reg_write, r_mem_read, r_mem_write, r_alu_src, r_mem_to_reg;
    logic [1:0] r_alu_op;
    logic       r_id, r_ex, r_mem, r_wb, r_ill, r_req, r_busy;
    logic [2:0] w_new_op, w_op;
    logic       w_is_mem, w_is_alu, w_is_jump;
    state_t     w_end_state;

    // w_new_op decodes the byte arriving on the bus; w_op the latched instruction
    assign w_new_op    = bus.rdata[7:5];
    assign w_op        = r_instr[7:5];
    assign w_is_mem    = w_op == 3'd0 || w_op == 3'd1;
    assign w_is_alu    = w_op == 3'd3 || w_op == 3'd4 || w_op == 3'd5;
    assign w_is_jump   = w_op == 3'd2;
    assign w_end_state = i_run ? S_FETCH : S_IDLE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_pc         <= RESET_PC;
            r_instr      <= '0;
            r_reg_write  <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_alu_src    <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_alu_op     <= 2'b00;
            r_id         <= 1'b0;
            r_ex         <= 1'b0;
            r_mem        <= 1'b0;
            r_wb         <= 1'b0;
            r_ill        <= 1'b0;
            r_req        <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (i_run) begin
                    r_state <= S_FETCH;
                    r_req   <= 1'b1;
                    r_busy  <= 1'b1;
                end
                S_FETCH: if (bus.ack) begin
                    // controls are registered here so they are valid throughout DECODE
                    r_state      <= S_DECODE;
                    r_req        <= 1'b0;
                    r_instr      <= bus.rdata;
                    r_reg_write  <= w_new_op == 3'd0 || w_new_op == 3'd3 || w_new_op == 3'd4 || w_new_op == 3'd5;
                    r_mem_read   <= w_new_op == 3'd0;
                    r_mem_write  <= w_new_op == 3'd1;
                    r_alu_src    <= w_new_op == 3'd0 || w_new_op == 3'd1 || w_new_op == 3'd4;
                    r_mem_to_reg <= w_new_op == 3'd0;
                    r_alu_op     <= w_new_op == 3'd5 ? 2'b01 : 2'b00;
                    r_ill        <= r_ill | (&w_new_op[2:1]);
                    r_id         <= ~r_id;
                end
                S_DECODE: begin
                    r_state <= S_EXECUTE;
                    r_ex    <= ~r_ex;
                end
                S_EXECUTE: begin
                    r_pc <= w_is_jump ? r_instr[4:0] : r_pc + 5'd1;
                    if (w_is_mem) begin
                        r_state <= S_MEMORY;
                        r_mem   <= ~r_mem;
                    end else if (w_is_alu) begin
                        r_state <= S_WRITEBACK;
                        r_wb    <= ~r_wb;
`ifdef FDC_HALT_ON_ILLEGAL_EN
                    end else if (&w_op[2:1]) begin
                        r_state <= S_HALTED;
                        r_busy  <= 1'b0;
`else
`endif
                    end else begin
                        r_state <= w_end_state;
                        r_req   <= i_run;
                        r_busy  <= i_run;
                    end
                end
                S_MEMORY: if (w_op == 3'd0) begin
                    r_state <= S_WRITEBACK;
                    r_wb    <= ~r_wb;
                end else begin
                    r_state <= w_end_state;
                    r_req   <= i_run;
                    r_busy  <= i_run;
                end
                S_WRITEBACK: begin
                    r_state <= w_end_state;
                    r_req   <= i_run;
                    r_busy  <= i_run;
                end
                default: r_state <= r_state;
            endcase
        end
    end

    assign bus.req       = r_req;
    assign bus.addr      = r_pc;
    assign o_instruction = r_instr;
    assign o_rt_or_rd    = r_instr[4];
    assign o_rs          = r_instr[3];
    assign o_imm         = r_instr[2:0];
    assign o_reg_write   = r_reg_write;
    assign o_mem_read    = r_mem_read;
    assign o_mem_write   = r_mem_write;
    assign o_alu_src     = r_alu_src;
    assign o_mem_to_reg  = r_mem_to_reg;
    assign o_alu_op      = r_alu_op;
    assign o_id_stage    = r_id;
    assign o_ex_stage    = r_ex;
    assign o_mem_stage   = r_mem;
    assign o_wb_stage    = r_wb;
    assign o_pc          = r_pc;
    assign o_illegal_op  = r_ill;
    assign o_busy        = r_busy;
endmodule

// File: tb/tb_fetch_decode_ctrl.sv
// tb_fetch_decode_ctrl: self-checking bench for fetch_decode_ctrl.
module tb_fetch_decode_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic run = 1'b0;
    always #5 clk = ~clk;

    fetch_decode_ctrl_if bus();
    logic [7:0] o_instruction;
    logic       o_rt_or_rd, o_rs;
    logic [2:0] o_imm;
    logic       o_reg_write, o_mem_read, o_mem_write, o_alu_src, o_mem_to_reg;
    logic [1:0] o_alu_op;
    logic       o_id_stage, o_ex_stage, o_mem_stage, o_wb_stage;
    logic [4:0] o_pc;
    logic       o_illegal_op, o_busy;

    fetch_decode_ctrl dut (
        .clk(clk), .rst_n(rst_n), .i_run(run), .bus(bus.master),
        .o_instruction(o_instruction), .o_rt_or_rd(o_rt_or_rd), .o_rs(o_rs), .o_imm(o_imm),
        .o_reg_write(o_reg_write), .o_mem_read(o_mem_read), .o_mem_write(o_mem_write),
        .o_alu_src(o_alu_src), .o_mem_to_reg(o_mem_to_reg), .o_alu_op(o_alu_op),
        .o_id_stage(o_id_stage), .o_ex_stage(o_ex_stage), .o_mem_stage(o_mem_stage),
        .o_wb_stage(o_wb_stage), .o_pc(o_pc), .o_illegal_op(o_illegal_op), .o_busy(o_busy)
    );

    int n_tests = 0, n_fail = 0, cyc = 0;
    logic [7:0] mem [32];
    logic run_cmd = 1'b0;
    int wait_fixed = 0, wait_cnt = 0;
    // reference model: fetch flag, cycles since ack (k), architectural state
    logic m_fetch, m_halt, m_ill;
    int k;
    logic [4:0] m_pc;
    logic [7:0] m_instr;
    logic [6:0] m_ctl;
    logic [3:0] m_tog;
    // DUT event history for literal timing checks
    logic [3:0] p_tog;
    int ack_c, ack_n = 0, id_c, mem_c, wb_c, mem_n = 0, wb_n = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out (cycle %0d)", name, cyc);
    endtask

    // {RegWrite, MemRead, MemWrite, ALUSrc, MemToReg, ALUOp}
    function automatic logic [6:0] dec(input logic [2:0] op);
        case (op)
            3'd0: return 7'b11011_00;
            3'd1: return 7'b00110_00;
            3'd3: return 7'b10000_00;
            3'd4: return 7'b10010_00;
            3'd5: return 7'b10000_01;
            default: return 7'b00000_00;
        endcase
    endfunction

    function automatic int cpi(input logic [2:0] op);
        return op == 3'd0 ? 5 : (op == 3'd1 || op == 3'd3 || op == 3'd4 || op == 3'd5) ? 4 : 3;
    endfunction

    function automatic int pick();
        return wait_fixed >= 0 ? wait_fixed : int'($urandom_range(0, 3));
    endfunction

    always @(negedge clk) begin
        logic la, was_fetch, last;
        logic [7:0] lr;
        logic [2:0] op;
        if (!rst_n) begin
            m_fetch = 0; m_halt = 0; m_ill = 0; k = 0; m_pc = 5'd0;
            m_instr = 8'h00; m_ctl = 7'd0; m_tog = 4'd0; p_tog = 4'd0;
        end
        chk("req", bus.req, m_fetch);
        chk("addr", bus.addr, m_pc);
        chk("pc", o_pc, m_pc);
        chk("busy", o_busy, m_fetch || k > 0);
        chk("instr", o_instruction, m_instr);
        chk("fields", {o_rt_or_rd, o_rs, o_imm}, m_instr[4:0]);
        chk("ctl", {o_reg_write, o_mem_read, o_mem_write, o_alu_src, o_mem_to_reg, o_alu_op}, m_ctl);
        chk("toggles", {o_id_stage, o_ex_stage, o_mem_stage, o_wb_stage}, m_tog);
        chk("illegal", o_illegal_op, m_ill);
        if (o_id_stage !== p_tog[3]) id_c = cyc;
        if (o_mem_stage !== p_tog[1]) begin mem_c = cyc; mem_n++; end
        if (o_wb_stage !== p_tog[0]) begin wb_c = cyc; wb_n++; end
        p_tog = {o_id_stage, o_ex_stage, o_mem_stage, o_wb_stage};
        run = run_cmd;
        lr = 8'($urandom);
        la = 1'($urandom_range(0, 1));
        if (m_fetch) begin
            la = wait_cnt == 0;
            if (la) begin lr = mem[m_pc]; ack_c = cyc; ack_n++; end
            else wait_cnt--;
        end
        bus.ack = la;
        bus.rdata = lr;
        was_fetch = m_fetch;
        if (k > 0) begin
            op = m_instr[7:5];
            last = k == cpi(op) - 1;
            if (k + 1 == 2) m_tog[2] = ~m_tog[2];
            if (k + 1 == 3) begin
                m_pc = op == 3'd2 ? m_instr[4:0] : m_pc + 5'd1;
                if (op <= 3'd1) m_tog[1] = ~m_tog[1];
                if (op >= 3'd3 && op <= 3'd5) m_tog[0] = ~m_tog[0];
            end
            if (k + 1 == 4 && op == 3'd0) m_tog[0] = ~m_tog[0];
            if (last) begin
                k = 0;
`ifdef FDC_HALT_ON_ILLEGAL_EN
                if (op >= 3'd6) m_halt = 1; else m_fetch = run;
`else
                m_fetch = run;
`endif
            end else k++;
        end else if (m_fetch) begin
            if (la) begin
                k = 1; m_fetch = 0; m_instr = lr; m_ctl = dec(lr[7:5]);
                m_ill = m_ill | (lr[7:6] == 2'b11);
                m_tog[3] = ~m_tog[3];
            end
        end else if (!m_halt && run) m_fetch = 1;
        if (m_fetch && !was_fetch) wait_cnt = pick();
        cyc++;
    end

    task automatic wait_ack();
        int a0 = ack_n;
        for (int i = 0; i < 60 && ack_n == a0; i++) @(posedge clk);
        if (ack_n == a0) timeout("ack");
    endtask

    task automatic run_one(input int w);
        wait_fixed = w;
        run_cmd = 1'b1;
        wait_ack();
        run_cmd = 1'b0;
        for (int i = 0; i < 20 && (o_busy || bus.req); i++) @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        run_cmd = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        int exp_pc, m0, w0;
        for (int i = 0; i < 32; i++) mem[i] = 8'h00;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk); #1;
        chk("rst_pc", o_pc, 5'd0);
        chk("rst_req", bus.req, 1'b0);
        chk("rst_busy", o_busy, 1'b0);

        mem[0] = 8'h6C;
        run_one(2);
        chk("add_id_lat", id_c - ack_c, 1);
        chk("add_wb_lat", wb_c - ack_c, 3);
        chk("add_regwrite", o_reg_write, 1'b1);
        chk("add_aluop", o_alu_op, 2'b00);
        chk("add_pc", o_pc, 5'd1);

        mem[1] = 8'h0B;
        run_one(0);
        chk("lw_ctl", {o_mem_read, o_mem_to_reg, o_alu_src}, 3'b111);
        chk("lw_imm", o_imm, 3'd3);
        chk("lw_mem_lat", mem_c - ack_c, 3);
        chk("lw_wb_lat", wb_c - ack_c, 4);
        chk("lw_pc", o_pc, 5'd2);

        mem[2] = 8'h44;
        run_one(1);
        chk("jmp_pc", o_pc, 5'd4);

        mem[4] = 8'h35;
        w0 = wb_n;
        run_one(0);
        chk("sw_memwrite", o_mem_write, 1'b1);
        chk("sw_regwrite", o_reg_write, 1'b0);
        chk("sw_no_wb", wb_n, w0);
        chk("sw_pc", o_pc, 5'd5);
        chk("sw_addr", bus.addr, 5'd5);

        mem[5] = 8'h5F;
        run_one(0);
        chk("jmp31_pc", o_pc, 5'd31);
        mem[31] = 8'h5E;
        m0 = mem_n; w0 = wb_n;
        run_one(0);
        chk("jmp30_pc", o_pc, 5'd30);
        chk("jmp_no_mem", mem_n, m0);
        chk("jmp_no_wb", wb_n, w0);
        mem[30] = 8'h5F;
        run_one(0);
        mem[31] = 8'h81;
        run_one(0);
        chk("addi_wrap_pc", o_pc, 5'd0);
        chk("addi_alusrc", o_alu_src, 1'b1);

        mem[0] = 8'hE0;
        run_one(0);
        chk("ill_flag", o_illegal_op, 1'b1);
`ifdef FDC_HALT_ON_ILLEGAL_EN
        run_cmd = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk); #1;
        chk("halt_busy", o_busy, 1'b0);
        chk("halt_req", bus.req, 1'b0);
        do_reset();
        exp_pc = 0;
`else
        chk("ill_pc", o_pc, 5'd1);
        exp_pc = 1;
`endif
        mem[0] = 8'hA5;
        mem[1] = 8'hA5;
        wait_fixed = 0;
        run_cmd = 1'b1;
        wait_ack();
        @(posedge clk);
        run_cmd = 1'b0;
        for (int i = 0; i < 20 && o_busy; i++) @(posedge clk);
        @(negedge clk); #1;
        chk("sub_wb_lat", wb_c - ack_c, 3);
        chk("sub_aluop", o_alu_op, 2'b01);
        chk("sub_idle", o_busy, 1'b0);
        chk("sub_pc", o_pc, 5'(exp_pc + 1));

        wait_fixed = 20;
        run_cmd = 1'b1;
        for (int i = 0; i < 20 && !bus.req; i++) @(posedge clk);
        if (!bus.req) timeout("req_rise");
        @(posedge clk);
        #3 rst_n = 1'b0;
        run_cmd = 1'b0;
        #1;
        chk("arst_req", bus.req, 1'b0);
        chk("arst_pc", o_pc, 5'd0);
        chk("arst_busy", o_busy, 1'b0);
        chk("arst_ill", o_illegal_op, 1'b0);
        chk("arst_instr", o_instruction, 8'h00);
        @(negedge clk);
        #2 rst_n = 1'b1;

        for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
        wait_fixed = -1;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            if (i % 25 == 0) run_cmd = $urandom_range(0, 7) != 0;
            if (i % 700 == 699) do_reset();
        end
        run_cmd = 1'b0;
        repeat (10) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
